// File: rtl/stump_mem_responder_if.sv
// Bus between the Stump core side and the memory responder.
// Handshake: the processor drives address/wdata with a mem_ren or mem_wen strobe.
// A read answers combinationally in the same cycle. A write commits on the next rising clock edge.
// The output byte stream uses valid/ready: a byte transfers on any rising edge where tx_valid and
// tx_ready are both high, and tx_data holds steady while tx_valid is high and tx_ready is low.
interface stump_mem_responder_if;
    logic [15:0] address;
    logic [15:0] wdata;
    logic        mem_ren;
    logic        mem_wen;
    logic [15:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_match;

    // Processor / consumer side.
    modport master (
        output address, wdata, mem_ren, mem_wen, tx_ready,
        input  rdata, tx_data, tx_valid, timer_match
    );

    // Memory responder side.
    modport slave (
        input  address, wdata, mem_ren, mem_wen, tx_ready,
        output rdata, tx_data, tx_valid, timer_match
    );
endinterface

// File: rtl/stump_mem_responder.sv
// Memory-side responder for the Stump bus.
// It holds a word-addressed RAM and an I/O page at the top of the address space.
// The I/O page contains a TX byte FIFO, a STATUS register, a free-running TIMER and TIMER_CMP.
module stump_mem_responder #(
    parameter int          RAM_ADDR_BITS = 10,
    parameter logic [15:0] IO_BASE       = 16'hFF00,
    parameter int          FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    stump_mem_responder_if.slave  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Storage (RAM contents survive reset)
    logic [15:0] mem_q [2**RAM_ADDR_BITS];
    logic [7:0]  fifo_q [FIFO_DEPTH];

    // Control state
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [15:0]      timer_q, timer_d;
    logic [15:0]      cmp_q, cmp_d;
    logic             match_q, match_d;

    // Decode
    logic                     is_io;
    logic [15:0]              io_off;
    logic [RAM_ADDR_BITS-1:0] ram_idx;
    logic                     wr_en;
    logic                     err_evt;
    logic                     push, pop, push_ok, ovf_evt;
    logic                     full, empty;
    logic                     status_wr, timer_wr, cmp_wr;
    logic [15:0]              status_w;

    assign is_io   = (bus.address >= IO_BASE);
    assign io_off  = bus.address - IO_BASE;
    assign ram_idx = bus.address[RAM_ADDR_BITS-1:0];

    // A simultaneous read and write strobe is a bus error.
    // The read still happens, but the write is dropped.
    assign err_evt = bus.mem_wen & bus.mem_ren;
    assign wr_en   = bus.mem_wen & ~bus.mem_ren;

    assign status_wr = wr_en & is_io & (io_off == 16'd1);
    assign timer_wr  = wr_en & is_io & (io_off == 16'd2);
    assign cmp_wr    = wr_en & is_io & (io_off == 16'd3);

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = wr_en & is_io & (io_off == 16'd0);
    assign pop   = ~empty & bus.tx_ready;
    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
    assign push_ok = push & (~full | pop);
    assign ovf_evt = push & full & ~pop;

    // STATUS reflects register state before the current edge
    always_comb begin
        status_w      = '0;
        status_w[0]   = full;
        status_w[1]   = empty;
        status_w[4:2] = 3'(count_q);
        status_w[8]   = ovf_q;
        status_w[9]   = err_q;
    end

    // Zero-wait-state read mux; idle bus returns 0
    always_comb begin
        bus.rdata = '0;
        if (bus.mem_ren) begin
            if (!is_io) begin
                bus.rdata = mem_q[ram_idx];
            end else begin
                case (io_off)
                    16'd1:   bus.rdata = status_w;
                    16'd2:   bus.rdata = timer_q;
                    16'd3:   bus.rdata = cmp_q;
                    default: bus.rdata = '0;
                endcase
            end
        end
    end

    assign bus.tx_valid    = ~empty;
    assign bus.tx_data     = empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign bus.timer_match = match_q;

    // Next-state for FIFO pointers/count, sticky flags and timer
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // An error event beats a STATUS write that would clear the flag.
        ovf_d = ovf_evt ? 1'b1 : (status_wr ? 1'b0 : ovf_q);
        err_d = err_evt ? 1'b1 : (status_wr ? 1'b0 : err_q);

        timer_d = timer_wr ? bus.wdata : timer_q + 16'd1;
        cmp_d   = cmp_wr ? bus.wdata : cmp_q;
        // A TIMER write suppresses the compare for that cycle.
        match_d = (timer_q == cmp_q) & ~timer_wr;
    end

    // RAM write port; a write pending at reset is discarded
    always_ff @(posedge clk) begin
        if (!rst && wr_en && !is_io) begin
            mem_q[ram_idx] <= bus.wdata;
        end
    end

    // FIFO byte storage; only the pointers need resetting
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            fifo_q[wr_ptr_q] <= bus.wdata[7:0];
        end
    end

    // Control registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            timer_q  <= 16'h0000;
            cmp_q    <= 16'hFFFF;
            match_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            cmp_q    <= cmp_d;
            match_q  <= match_d;
        end
    end
endmodule

// File: tb/tb_stump_mem_responder.sv
// Directed bench for stump_mem_responder.
// Expected read data and TX bytes go into queues when stimulus is issued.
// A monitor drains those queues whenever the DUT presents a read or a TX handshake.
module tb_stump_mem_responder;
    logic clk;
    logic rst;

    stump_mem_responder_if bus ();

    stump_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    logic [15:0] rd_exp_q[$];
    logic [7:0]  tx_exp_q[$];
    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample on the falling edge, away from the active edge
    task automatic monitor();
        logic [15:0] e16;
        logic [7:0]  e8;
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_ren) begin
                if (rd_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got %h expected no read at %0t", bus.rdata, $time);
                end else begin
                    e16 = rd_exp_q.pop_front();
                    check("rdata", bus.rdata, e16);
                end
            end
            if (!rst && bus.tx_valid && bus.tx_ready) begin
                if (tx_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got %h expected no byte at %0t", bus.tx_data, $time);
                end else begin
                    e8 = tx_exp_q.pop_front();
                    check("tx_data", {8'h00, bus.tx_data}, {8'h00, e8});
                end
            end
        end
    endtask

    // Driver tasks: entered just after a rising edge, and return just after the next one
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus.address = a;
        bus.wdata   = d;
        bus.mem_ren = 1'b0;
        bus.mem_wen = 1'b1;
        tick();
        bus.mem_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [15:0] exp);
        rd_exp_q.push_back(exp);
        bus.address = a;
        bus.mem_ren = 1'b1;
        bus.mem_wen = 1'b0;
        tick();
        bus.mem_ren = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.address  = '0;
        bus.wdata    = '0;
        bus.mem_ren  = 1'b0;
        bus.mem_wen  = 1'b0;
        bus.tx_ready = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_tx_valid", {15'h0, bus.tx_valid}, 16'h0000);
        check("rst_tx_data", {8'h00, bus.tx_data}, 16'h0000);
        check("rst_timer_match", {15'h0, bus.timer_match}, 16'h0000);
        bus_read(16'hFF02, 16'h0000);
        bus_read(16'hFF01, 16'h0002);
        bus_read(16'hFF03, 16'hFFFF);

        // RAM, aliasing, idle bus, unmapped I/O
        bus_write(16'h0005, 16'hBEEF);
        bus_read(16'h0005, 16'hBEEF);
        bus_read(16'h0405, 16'hBEEF);
        bus_write(16'hFEFF, 16'hA5A5);
        bus_read(16'h02FF, 16'hA5A5);
        bus_read(16'hFF07, 16'h0000);
        bus_read(16'hFF00, 16'h0000);
        bus.address = 16'h0005;
        #1 check("idle_rdata", bus.rdata, 16'h0000);

        // Bus error: read wins, write suppressed, sticky flag
        rd_exp_q.push_back(16'hBEEF);
        bus.address = 16'h0005;
        bus.wdata   = 16'h1234;
        bus.mem_ren = 1'b1;
        bus.mem_wen = 1'b1;
        tick();
        bus.mem_ren = 1'b0;
        bus.mem_wen = 1'b0;
        bus_read(16'h0005, 16'hBEEF);
        bus_read(16'hFF01, 16'h0202);
        bus_write(16'hFF01, 16'h0000);
        bus_read(16'hFF01, 16'h0002);

        // FIFO fill and overflow
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_write(16'hFF00, {8'hAB, 8'h41 + 8'(i)});
            if (i < 4) tx_exp_q.push_back(8'h41 + 8'(i));
        end
        check("hold_tx_data_0", {8'h00, bus.tx_data}, 16'h0041);
        tick();
        check("hold_tx_data_1", {8'h00, bus.tx_data}, 16'h0041);
        bus_read(16'hFF01, 16'h0111);
        bus.tx_ready = 1'b1;
        repeat (6) tick();
        check("drain_tx_valid", {15'h0, bus.tx_valid}, 16'h0000);
        check("drain_tx_q", 16'(tx_exp_q.size()), 16'h0000);
        bus.tx_ready = 1'b0;
        bus_read(16'hFF01, 16'h0102);
        bus_write(16'hFF01, 16'hFFFF);
        bus_read(16'hFF01, 16'h0002);

        // Push and pop together on a full FIFO
        for (int i = 0; i < 4; i++) begin
            bus_write(16'hFF00, {8'h00, 8'h61 + 8'(i)});
            tx_exp_q.push_back(8'h61 + 8'(i));
        end
        tx_exp_q.push_back(8'h55);
        bus.tx_ready = 1'b1;
        bus_write(16'hFF00, 16'h0055);
        bus.tx_ready = 1'b0;
        bus_read(16'hFF01, 16'h0011);
        bus.tx_ready = 1'b1;
        repeat (6) tick();
        check("pp_tx_valid", {15'h0, bus.tx_valid}, 16'h0000);
        check("pp_tx_q", 16'(tx_exp_q.size()), 16'h0000);
        bus.tx_ready = 1'b0;

        // Push and pop together with one entry: the new byte becomes the head
        bus_write(16'hFF00, 16'h0071);
        tx_exp_q.push_back(8'h71);
        tx_exp_q.push_back(8'h72);
        bus.tx_ready = 1'b1;
        bus_write(16'hFF00, 16'h0072);
        bus.tx_ready = 1'b0;
        check("one_head", {8'h00, bus.tx_data}, 16'h0072);
        bus_read(16'hFF01, 16'h0004);
        bus.tx_ready = 1'b1;
        repeat (3) tick();
        bus.tx_ready = 1'b0;
        check("one_tx_q", 16'(tx_exp_q.size()), 16'h0000);

        // Timer wrap and compare
        bus_write(16'hFF03, 16'h0000);
        bus_write(16'hFF02, 16'hFFFE);
        bus_read(16'hFF02, 16'hFFFE);
        bus_read(16'hFF02, 16'hFFFF);
        check("match_before", {15'h0, bus.timer_match}, 16'h0000);
        bus_read(16'hFF02, 16'h0000);
        check("match_pulse", {15'h0, bus.timer_match}, 16'h0001);
        tick();
        check("match_after", {15'h0, bus.timer_match}, 16'h0000);
        bus_read(16'hFF03, 16'h0000);

        // No match on a cycle in which TIMER is being written
        bus_write(16'hFF03, 16'h0010);
        bus_write(16'hFF02, 16'h0010);
        bus_write(16'hFF02, 16'h0010);
        check("match_wr_suppress", {15'h0, bus.timer_match}, 16'h0000);
        tick();
        check("match_after_wr", {15'h0, bus.timer_match}, 16'h0001);
        tick();
        check("match_clear", {15'h0, bus.timer_match}, 16'h0000);

        // Asynchronous reset in the middle of a pending write
        bus_write(16'hFF00, 16'h0077);
        bus.address = 16'hFF00;
        bus.wdata   = 16'h0088;
        bus.mem_wen = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_tx_valid", {15'h0, bus.tx_valid}, 16'h0000);
        check("arst_tx_data", {8'h00, bus.tx_data}, 16'h0000);
        tick();
        bus.mem_wen = 1'b0;
        tx_exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        bus_read(16'hFF02, 16'h0000);
        bus_read(16'hFF01, 16'h0002);
        bus_read(16'hFF03, 16'hFFFF);
        bus_read(16'h0005, 16'hBEEF);
        bus.tx_ready = 1'b1;
        repeat (2) tick();
        bus.tx_ready = 1'b0;
        check("arst_fifo_empty", {15'h0, bus.tx_valid}, 16'h0000);

        // Final report
        tick();
        check("rd_q_drained", 16'(rd_exp_q.size()), 16'h0000);
        check("tx_q_drained", 16'(tx_exp_q.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
